pfiform_pop_sched: RTL
======================

Name: pfiform_pop_sched

Overview:
- Read-side scheduler for the PFIFORM packing FIFO (6-bit soft bits, up to 32 per beat, 64-entry window).
- Accepts a job of N soft bits and a preferred chunk size, then drives PopAmout/PopPermit to drain exactly N soft bits in chunk-sized pops, with a short final pop where needed.
- Registers each popped beat into a one-deep output stage with valid/ready backpressure toward the rate-dematching consumer.
- Signals job completion with a one-cycle pulse.

Parameters:
- SB_W, 6, bits per soft bit.
- AMT_W, 5, width of the minus-one amount fields (max 32 soft bits per beat).
- LEN_W, 16, width of the job length and progress counters.

Ports:
- i_core_clk  in  1  system clock; all state updates on the rising edge.
- i_rx_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  job start strobe; sampled only in IDLE.
- i_job_len  in  LEN_W  number of soft bits in the job (actual count; 0 allowed).
- i_chunk_amt  in  AMT_W  preferred soft bits per pop, minus one.
- i_abort  in  1  cancels the current job.
- o_pop_amout  out  AMT_W  to FIFO PopAmout: soft bits requested this cycle, minus one.
- o_pop_permit  out  1  to FIFO PopPermit.
- i_pop_enable  in  1  from FIFO PopEnable: pop executed this cycle.
- i_pop_data  in  32*SB_W  from FIFO PopData, LSB aligned.
- o_out_valid  out  1  output beat valid.
- o_out_data  out  32*SB_W  registered beat, LSB aligned, bits above (o_out_amt+1)*6 are zero.
- o_out_amt  out  AMT_W  soft bits in the beat, minus one.
- o_out_last  out  1  beat is the final beat of the job.
- i_out_ready  in  1  consumer accepts the beat.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_pop_cnt  out  LEN_W  soft bits popped so far in the current job.

Behaviour:
- Reset values: all outputs 0; state IDLE; remaining count, latched chunk size and output stage cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On i_start with i_job_len != 0: latch length into remaining and latch the chunk size; clear o_pop_cnt; go to RUN.
  - On i_start with i_job_len == 0: go to DONE; no pops are issued.
- RUN:
  - o_pop_amout = min(chunk+1, remaining) - 1, combinational from registered values only.
  - o_pop_permit = (state==RUN) && (!o_out_valid || i_out_ready).
  - i_pop_enable is honoured only while o_pop_permit is high; otherwise it is ignored.
  - On an honoured pop:
    - o_out_data <= i_pop_data.
    - o_out_amt <= o_pop_amout.
    - o_out_valid <= 1.
    - o_out_last <= (remaining == o_pop_amout+1).
    - remaining -= o_pop_amout+1.
    - o_pop_cnt += o_pop_amout+1.
  - If that pop was the last, go to DRAIN.
- Output stage:
  - Beat transfers when o_out_valid && i_out_ready.
  - On transfer with no new pop in the same cycle, o_out_valid <= 0.
  - Transfer and new pop in the same cycle: the new beat replaces the old one with no bubble (full throughput, one beat per cycle).
- DRAIN: o_pop_permit = 0. When the last beat transfers, go to DONE.
- DONE: o_done = 1 for exactly one cycle; then go to IDLE. o_busy is high in DONE.
- Latency: pop at cycle t gives o_out_valid at t+1. Start at t gives the first possible o_pop_permit at t+1.
- i_abort (any non-IDLE state, highest priority):
  - Next state IDLE.
  - o_out_valid, o_out_last and o_pop_permit cleared.
  - No o_done pulse.
  - o_pop_cnt holds its value for debug.
  - A pop honoured in the abort cycle is dropped.
- i_start while o_busy: ignored, with no effect on latched job values.
- Chunk latch: a chunk amount of 31 requests 32 soft bits. The chunk size is latched per job; mid-job changes to i_chunk_amt have no effect.
- Arithmetic: remaining and o_pop_cnt are LEN_W unsigned. Remaining never underflows, because the min() clamp guarantees this.
- Reset asserted mid-job: immediate return to the reset values above; no o_done pulse.

Test Plan:
- Len 70, chunk_amt 31, FIFO always popping, i_out_ready=1 → three pops with o_pop_amout 31, 31, 5; o_out_last only on the third beat; o_pop_cnt=70; o_done one cycle after the third beat transfers.
- Len 64, chunk_amt 7, i_out_ready toggled 1,0,1,0 → o_pop_permit low whenever o_out_valid && !i_out_ready; o_out_data is stable while stalled; 8 beats of 8 soft bits each; no beat lost or duplicated.
- Len 0 start → o_busy high for 1 cycle (DONE), o_done pulse, o_pop_permit never asserted.
- Len 100, chunk_amt 15, i_abort after the 2nd pop → next cycle IDLE, o_out_valid=0, no o_done, o_pop_cnt=32; a following start with len 16 runs normally.
- i_start pulsed during RUN with a different len and chunk → ignored; the original job completes with the original pop sizes.
- i_rx_rst asserted asynchronously mid-RUN (between clock edges) → all outputs 0 immediately; after release, the block idles until the next i_start.

Source files
------------

// File: rtl/pfiform_pop_sched.sv
// rtl/pfiform_pop_sched.sv - read-side pop scheduler for the PFIFORM packing FIFO
//
// Drains a job of N soft bits from the packing FIFO in chunk-sized pops.
// The final pop is shorter when N is not a multiple of the chunk. Each
// popped beat is registered into a one-deep output stage with valid/ready
// backpressure, and a one-cycle pulse marks job completion.
//
// Ports:
//   i_core_clk    system clock, rising edge
//   i_rx_rst      asynchronous active-high reset
//   i_start       job start strobe, sampled only while idle
//   i_job_len     soft bits in the job (0 allowed)
//   i_chunk_amt   preferred soft bits per pop, minus one
//   i_abort       cancel the current job
//   o_pop_amout   FIFO PopAmout: soft bits requested, minus one
//   o_pop_permit  FIFO PopPermit
//   i_pop_enable  FIFO PopEnable: pop executed this cycle
//   i_pop_data    FIFO PopData, LSB aligned
//   o_out_valid   output beat valid
//   o_out_data    output beat, LSB aligned, unused soft bits zeroed
//   o_out_amt     soft bits in the beat, minus one
//   o_out_last    final beat of the job
//   i_out_ready   consumer accepts the beat
//   o_busy        high whenever not idle
//   o_done        one-cycle completion pulse
//   o_pop_cnt     soft bits popped so far in the current job

module pfiform_pop_sched #(
    parameter int SB_W  = 6,
    parameter int AMT_W = 5,
    parameter int LEN_W = 16
) (
    input  logic                 i_core_clk,
    input  logic                 i_rx_rst,
    input  logic                 i_start,
    input  logic [LEN_W-1:0]     i_job_len,
    input  logic [AMT_W-1:0]     i_chunk_amt,
    input  logic                 i_abort,
    output logic [AMT_W-1:0]     o_pop_amout,
    output logic                 o_pop_permit,
    input  logic                 i_pop_enable,
    input  logic [32*SB_W-1:0]   i_pop_data,
    output logic                 o_out_valid,
    output logic [32*SB_W-1:0]   o_out_data,
    output logic [AMT_W-1:0]     o_out_amt,
    output logic                 o_out_last,
    input  logic                 i_out_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [LEN_W-1:0]     o_pop_cnt
);

    localparam int BEAT_W = 32 * SB_W;
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t nextState;

    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  popCnt;
    logic [AMT_W-1:0]  chunkAmt;
    logic [BEAT_W-1:0] outData;
    logic [AMT_W-1:0]  outAmt;
    logic              outValid;
    logic              outLast;

    logic [LEN_W-1:0]  chunkLen;
    logic [LEN_W-1:0]  popTake;
    logic              lastPop;
    logic              popPermit;
    logic [AMT_W-1:0]  popAmout;
    logic              popFire;
    logic              outXfer;
    logic              busy;
    logic              done;
    logic [BEAT_W-1:0] maskedData;

    // Pop size is the latched chunk clamped to what is left; the clamp is
    // what keeps remaining from ever wrapping below zero.
    assign chunkLen = {{(LEN_W-AMT_W){1'b0}}, chunkAmt} + ONE;
    assign popTake  = (remaining < chunkLen) ? remaining : chunkLen;
    assign lastPop  = (remaining == popTake);
    assign popFire  = popPermit && i_pop_enable;
    assign outXfer  = outValid && i_out_ready;

    // FIFO data above the requested amount is not guaranteed clean, so the
    // unused soft-bit lanes are zeroed before the beat is registered.
    always_comb begin
        maskedData = '0;
        for (int i = 0; i < 32; i++) begin
            if (AMT_W'(i) <= popAmout) begin
                maskedData[i*SB_W +: SB_W] = i_pop_data[i*SB_W +: SB_W];
            end
        end
    end

    // State register
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        nextState = state;
        if (state != IDLE && i_abort) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        nextState = (i_job_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (popFire && lastPop) begin
                        nextState = DRAIN;
                    end
                end
                DRAIN: begin
                    if (outXfer) begin
                        nextState = DONE;
                    end
                end
                DONE: begin
                    nextState = IDLE;
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

    // Output decode; pops are only offered when the output stage can take
    // the beat this cycle, which is what gives one beat per cycle.
    always_comb begin
        popPermit = 1'b0;
        popAmout  = '0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            RUN: begin
                popPermit = !outValid || i_out_ready;
                popAmout  = AMT_W'(popTake - ONE);
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Job counters and the one-deep output stage
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            remaining <= '0;
            popCnt    <= '0;
            chunkAmt  <= '0;
            outData   <= '0;
            outAmt    <= '0;
            outValid  <= 1'b0;
            outLast   <= 1'b0;
        end else if (state == IDLE) begin
            if (i_start) begin
                remaining <= i_job_len;
                chunkAmt  <= i_chunk_amt;
                popCnt    <= '0;
            end
        end else if (i_abort) begin
            // popCnt is left as-is so the aborted progress stays visible
            outValid <= 1'b0;
            outLast  <= 1'b0;
        end else if (popFire) begin
            outData   <= maskedData;
            outAmt    <= popAmout;
            outValid  <= 1'b1;
            outLast   <= lastPop;
            remaining <= remaining - popTake;
            popCnt    <= popCnt + popTake;
        end else if (outXfer) begin
            outValid <= 1'b0;
            outLast  <= 1'b0;
        end
    end

    assign o_pop_amout  = popAmout;
    assign o_pop_permit = popPermit;
    assign o_out_valid  = outValid;
    assign o_out_data   = outData;
    assign o_out_amt    = outAmt;
    assign o_out_last   = outLast;
    assign o_busy       = busy;
    assign o_done       = done;
    assign o_pop_cnt    = popCnt;

endmodule
